draw_scheduler: RTL and testbench

- Frame-level sequencer and VGA write-port arbiter for the game display.
- On each game_pulse it runs every object painter (bird box, pipes, ...) in an erase pass at the old positions, then emits one update tick so game logic can move objects, then runs every painter in a draw pass at the new positions.
- Exactly one painter owns the single plot/x/y/colour port to the VGA adapter at any time.
- This replaces the per-painter erase/draw toggling and the game_tick_after_erase toggle.

---
 rtl/draw_pkg.sv | 19 +
 rtl/vga_port_mux.sv | 50 +++++
 rtl/draw_scheduler.sv | 159 +++++++++++++++
 tb/tb_draw_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared encodings for the frame draw scheduler: FSM states, palette and screen size.
package draw_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t E_START = 3'd1;
  localparam state_t E_WAIT  = 3'd2;
  localparam state_t UPDATE  = 3'd3;
  localparam state_t D_START = 3'd4;
  localparam state_t D_WAIT  = 3'd5;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

endpackage

// File: rtl/vga_port_mux.sv
// N-to-1 selector for the shared VGA adapter write port; plot is gated by valid.
module vga_port_mux #(
  parameter int NUM_CLIENTS = 2,
  parameter int X_W         = 9,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                            valid,
  input  logic [IDX_W-1:0]                sel,
  input  logic [NUM_CLIENTS-1:0]          client_plot,
  input  logic [NUM_CLIENTS*X_W-1:0]      client_x,
  input  logic [NUM_CLIENTS*Y_W-1:0]      client_y,
  input  logic [NUM_CLIENTS*COLOUR_W-1:0] client_colour,
  output logic                            plot,
  output logic [X_W-1:0]                  x,
  output logic [Y_W-1:0]                  y,
  output logic [COLOUR_W-1:0]             colour
);

  logic [X_W-1:0]      x_arr      [NUM_CLIENTS];
  logic [Y_W-1:0]      y_arr      [NUM_CLIENTS];
  logic [COLOUR_W-1:0] colour_arr [NUM_CLIENTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign x_arr[gi]      = client_x[gi*X_W +: X_W];
      assign y_arr[gi]      = client_y[gi*Y_W +: Y_W];
      assign colour_arr[gi] = client_colour[gi*COLOUR_W +: COLOUR_W];
    end
  endgenerate

  // Compare-based select keeps out-of-range sel values at zero for non-power-of-two counts.
  always_comb begin
    plot   = 1'b0;
    x      = '0;
    y      = '0;
    colour = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (sel == IDX_W'(i)) begin
        plot   = valid & client_plot[i];
        x      = x_arr[i];
        y      = y_arr[i];
        colour = colour_arr[i];
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Frame sequencer: erase pass over all painters, one update tick, then draw pass,
// with exactly one painter owning the VGA write port at a time.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int X_W         = 9,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int TIMEOUT     = 20000
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic                            game_pulse,
  output logic [NUM_CLIENTS-1:0]          client_start,
  output logic                            client_erase,
  input  logic [NUM_CLIENTS-1:0]          client_done,
  input  logic [NUM_CLIENTS-1:0]          client_plot,
  input  logic [NUM_CLIENTS*X_W-1:0]      client_x,
  input  logic [NUM_CLIENTS*Y_W-1:0]      client_y,
  input  logic [NUM_CLIENTS*COLOUR_W-1:0] client_colour,
  output logic                            plot,
  output logic [X_W-1:0]                  x,
  output logic [Y_W-1:0]                  y,
  output logic [COLOUR_W-1:0]             colour,
  output logic                            update_tick,
  output logic                            frame_done,
  output logic                            busy,
  output logic                            timeout_err,
  output logic [7:0]                      overrun_count
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [15:0]      WD_LAST  = 16'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             pending_reg;
  logic [15:0]      wd_reg;
  logic             timeout_reg;
  logic [7:0]       overrun_reg;

  logic in_wait, is_start, expired, advance, last_client;

  assign in_wait     = (state_reg == E_WAIT) || (state_reg == D_WAIT);
  assign is_start    = (state_reg == E_START) || (state_reg == D_START);
  assign expired     = in_wait && (wd_reg == WD_LAST);
  // Only the selected client's done counts, and never in its start cycle.
  assign advance     = in_wait && (client_done[idx_reg] || expired);
  assign last_client = (idx_reg == LAST_IDX);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (game_pulse || pending_reg) begin
          state_next = E_START;
          idx_next   = '0;
        end
      end
      E_START: state_next = E_WAIT;
      E_WAIT: begin
        if (advance) begin
          if (last_client) begin
            idx_next   = '0;
            state_next = UPDATE;
          end else begin
            idx_next   = idx_reg + IDX_ONE;
            state_next = E_START;
          end
        end
      end
      UPDATE:  state_next = D_START;
      D_START: state_next = D_WAIT;
      D_WAIT: begin
        if (advance) begin
          if (last_client) begin
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next   = idx_reg + IDX_ONE;
            state_next = D_START;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_comb begin
    client_start = '0;
    if (is_start) client_start[idx_reg] = 1'b1;
    client_erase = (state_reg == E_START) || (state_reg == E_WAIT);
    update_tick  = (state_reg == UPDATE);
    frame_done   = (state_reg == D_WAIT) && advance && last_client;
    busy         = (state_reg != IDLE);
  end

  // Watchdog, frame-request queueing and error bookkeeping.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pending_reg <= 1'b0;
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
      overrun_reg <= '0;
    end else begin
      if (is_start) wd_reg <= '0;
      else if (in_wait) wd_reg <= wd_reg + 16'd1;

      if (expired) timeout_reg <= 1'b1;

      if (state_reg == IDLE) begin
        pending_reg <= 1'b0;
      end else if (game_pulse) begin
        if (!pending_reg) pending_reg <= 1'b1;
        else if (overrun_reg != 8'hFF) overrun_reg <= overrun_reg + 8'd1;
      end
    end
  end

  assign timeout_err   = timeout_reg;
  assign overrun_count = overrun_reg;

  vga_port_mux #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .X_W         (X_W),
    .Y_W         (Y_W),
    .COLOUR_W    (COLOUR_W),
    .IDX_W       (IDX_W)
  ) u_port_mux (
    .valid         (in_wait),
    .sel           (idx_reg),
    .client_plot   (client_plot),
    .client_x      (client_x),
    .client_y      (client_y),
    .client_colour (client_colour),
    .plot          (plot),
    .x             (x),
    .y             (y),
    .colour        (colour)
  );

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with two behavioural painter clients.
module tb_draw_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        gp_drv = 1'b0;
  logic        coinc_pulse = 1'b0;
  logic [1:0]  client_start;
  logic        client_erase;
  logic [1:0]  cdone = '0;
  logic [1:0]  cplot = '0;
  logic [8:0]  cx [2];
  logic [6:0]  cy [2];
  logic [2:0]  ccol [2];
  logic        plot;
  logic [8:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        update_tick, frame_done, busy, timeout_err;
  logic [7:0]  overrun_count;

  // Client behaviour knobs.
  logic hold1 = 1'b0;
  logic never_done0 = 1'b0;
  logic coinc_mode = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  draw_scheduler #(
    .NUM_CLIENTS (2),
    .X_W         (9),
    .Y_W         (7),
    .COLOUR_W    (3),
    .TIMEOUT     (16)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .game_pulse    (gp_drv | coinc_pulse),
    .client_start  (client_start),
    .client_erase  (client_erase),
    .client_done   (cdone),
    .client_plot   (cplot),
    .client_x      ({cx[1], cx[0]}),
    .client_y      ({cy[1], cy[0]}),
    .client_colour ({ccol[1], ccol[0]}),
    .plot          (plot),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .update_tick   (update_tick),
    .frame_done    (frame_done),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .overrun_count (overrun_count)
  );

  initial forever #5 clk = ~clk;

  // Painter model: after its start strobe, plot 3 pixels on 3 cycles, then pulse done.
  int cnt [2] = '{0, 0};
  always @(posedge clk) begin
    #1;
    coinc_pulse = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cdone[i] = 1'b0;
      if (reset) begin
        cnt[i] = 0; cplot[i] = 1'b0; cx[i] = '0; cy[i] = '0; ccol[i] = '0;
      end else if (client_start[i]) begin
        cnt[i] = 1; cplot[i] = 1'b0;
      end else if (cnt[i] >= 1 && cnt[i] <= 3) begin
        cplot[i] = 1'b1;
        cx[i] = 9'(10 + 40 * i + cnt[i]);
        cy[i] = 7'(20 + cnt[i]);
        ccol[i] = client_erase ? 3'b000 : 3'b010;
        cnt[i]++;
      end else if (cnt[i] == 4) begin
        cplot[i] = 1'b0;
        cnt[i] = 0;
        if (!(i == 0 && never_done0)) begin
          cdone[i] = 1'b1;
          if (i == 1 && !client_erase && coinc_mode) coinc_pulse = 1'b1;
        end
      end
      if (i == 1 && hold1) begin
        cplot[1] = 1'b1; cx[1] = 9'd100; cy[1] = 7'd99;
      end
    end
  end

  // Event log and port monitor, sampled on the falling edge.
  int log_code[$];
  int log_cyc[$];
  int cyc = 0, cur = 0, fd_cnt = 0, d0_cnt = 0;
  int plot_cnt = 0, erase_plots = 0, bad_order = 0, leak = 0, strobe_plot = 0;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (client_start[i]) begin
        cur = i;
        log_code.push_back((client_erase ? 10 : 20) + i);
        log_cyc.push_back(cyc);
        if (!client_erase && i == 0) d0_cnt++;
      end
    end
    if (update_tick) begin log_code.push_back(1); log_cyc.push_back(cyc); end
    if (frame_done) begin log_code.push_back(2); log_cyc.push_back(cyc); fd_cnt++; end
    if (plot) begin
      if (client_erase != (plot_cnt < 6)) bad_order++;
      plot_cnt++;
      if (client_erase) erase_plots++;
      if (cur == 0 && x == 9'd100) leak++;
      if (client_start != 2'b00 || update_tick) strobe_plot++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int code_at(input int i);
    return (i < log_code.size()) ? log_code[i] : -1;
  endfunction

  function automatic int gap(input int a, input int b);
    return (b < log_cyc.size() && a < log_cyc.size()) ? log_cyc[b] - log_cyc[a] : -1;
  endfunction

  task automatic clear_log();
    log_code.delete(); log_cyc.delete();
    plot_cnt = 0; erase_plots = 0; bad_order = 0; leak = 0; strobe_plot = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse();
    @(posedge clk); #1 gp_drv = 1'b1;
    @(posedge clk); #1 gp_drv = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int lim);
    int start = fd_cnt;
    int k = 0;
    while (fd_cnt == start && k < lim) begin @(negedge clk); k++; end
    check({tag, "_frame_done_seen"}, 32'(fd_cnt != start), 32'd1);
  endtask

  initial begin
    int k, fd_before;
    int exp_seq [6] = '{10, 11, 1, 20, 21, 2};

    // Reset state.
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_plot", 32'(plot), 0);
    check("rst_start", 32'(client_start), 0);
    check("rst_erase", 32'(client_erase), 0);
    check("rst_tick", 32'(update_tick), 0);
    check("rst_fdone", 32'(frame_done), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_overrun", 32'(overrun_count), 0);
    check("rst_xyc", {x, y, colour}, 0);

    // Basic frame: erase 0,1, tick, draw 0,1, frame_done; 12 plots, first 6 erase.
    clear_log();
    pulse();
    wait_fd("t1", 100);
    check("t1_log_len", 32'(log_code.size()), 6);
    for (int i = 0; i < 6; i++) check($sformatf("t1_seq%0d", i), 32'(code_at(i)), 32'(exp_seq[i]));
    check("t1_plots", 32'(plot_cnt), 12);
    check("t1_erase_plots", 32'(erase_plots), 6);
    check("t1_erase_order", 32'(bad_order), 0);
    check("t1_frame_len", 32'(gap(0, 5)), 20);
    $display("frame 1 done, %0d plots", plot_cnt);

    // game_pulse in the same cycle as the last done: next erase start 2 cycles later.
    repeat (3) @(negedge clk);
    clear_log();
    coinc_mode = 1'b1;
    pulse();
    wait_fd("t6a", 100);
    coinc_mode = 1'b0;
    wait_fd("t6b", 100);
    check("t6_fd_code", 32'(code_at(5)), 2);
    check("t6_next_start", 32'(code_at(6)), 10);
    check("t6_restart_gap", 32'(gap(5, 6)), 2);
    $display("coincident pulse frame pair done");

    // Pulses while busy: pending then overrun; then saturation.
    do_reset();
    clear_log();
    pulse();
    repeat (2) @(posedge clk);
    repeat (3) pulse();
    @(negedge clk);
    check("t3_overrun2", 32'(overrun_count), 2);
    wait_fd("t3a", 100);
    wait_fd("t3b", 100);
    check("t3_next_start", 32'(code_at(6)), 10);
    check("t3_restart_gap", 32'(gap(5, 6)), 2);
    repeat (10) @(negedge clk);
    check("t3_idle_after", 32'(busy), 0);
    @(posedge clk); #1 gp_drv = 1'b1;
    repeat (300) @(posedge clk);
    #1 gp_drv = 1'b0;
    @(negedge clk);
    check("t3_overrun_sat", 32'(overrun_count), 255);
    $display("overrun count %0d", overrun_count);

    // Client 1 holds plot; port must reflect only the selected client.
    do_reset();
    clear_log();
    hold1 = 1'b1;
    pulse();
    wait_fd("t2", 100);
    hold1 = 1'b0;
    check("t2_leak", 32'(leak), 0);
    check("t2_plot_in_strobe", 32'(strobe_plot), 0);
    check("t2_plots", 32'(plot_cnt), 14);
    $display("hold-plot frame done, %0d plots", plot_cnt);

    // Client 0 never finishes: watchdog of 16 wait cycles, then client 1 starts.
    do_reset();
    clear_log();
    never_done0 = 1'b1;
    pulse();
    wait_fd("t4", 200);
    never_done0 = 1'b0;
    check("t4_second", 32'(code_at(1)), 11);
    check("t4_wd_gap", 32'(gap(0, 1)), 17);
    check("t4_frame_len", 32'(gap(0, 5)), 44);
    check("t4_timeout", 32'(timeout_err), 1);
    repeat (20) @(negedge clk);
    check("t4_timeout_sticky", 32'(timeout_err), 1);
    $display("watchdog frame done");

    // Reset in D_WAIT aborts the frame cleanly.
    do_reset();
    check("t5_timeout_clr", 32'(timeout_err), 0);
    clear_log();
    pulse();
    repeat (2) @(posedge clk);
    repeat (2) pulse();
    @(negedge clk);
    check("t5_overrun_pre", 32'(overrun_count), 1);
    k = 0;
    while (d0_cnt == 0 && k < 200) begin @(negedge clk); k++; end
    check("t5_reached_draw", 32'(d0_cnt != 0), 1);
    @(posedge clk); #1 reset = 1'b1;
    fd_before = fd_cnt;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(busy), 0);
    check("t5_plot", 32'(plot), 0);
    check("t5_overrun", 32'(overrun_count), 0);
    repeat (10) @(negedge clk);
    check("t5_no_pending", 32'(busy), 0);
    check("t5_no_fdone", 32'(fd_cnt - fd_before), 0);
    clear_log();
    pulse();
    wait_fd("t5", 100);
    check("t5_clean_start", 32'(code_at(0)), 10);
    check("t5_plots", 32'(plot_cnt), 12);
    $display("post-reset frame done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
